// File: rtl/fifo_ctrl_sync_pkg.sv
// fifo_ctrl_sync_pkg: default geometry and flag thresholds for the FIFO controller
package fifo_ctrl_sync_pkg;
   localparam int DEF_DATA_DEPTH = 9;
   localparam int DEF_AE_LEVEL = 4;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping pointer incrementer with enable and synchronous reset
module fifo_ptr
   import fifo_ctrl_sync_pkg::*;
#(
   parameter int W = DEF_DATA_DEPTH + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] ptr
);
   // advance by one on each accepted request, rolling over naturally
   always_ff @(posedge clk)
      if (rst) ptr <= '0;
      else if (en) ptr <= ptr + 1'b1;
endmodule

// File: rtl/fifo_ctrl_sync.sv
// fifo_ctrl_sync: pointer, occupancy and status flag controller for a single-clock FIFO RAM
module fifo_ctrl_sync
   import fifo_ctrl_sync_pkg::*;
#(
   parameter int DATA_DEPTH = DEF_DATA_DEPTH,
   parameter int AF_LEVEL   = 2**DATA_DEPTH - 4,
   parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [DATA_DEPTH-1:0] waddr,
   output logic [DATA_DEPTH-1:0] raddr,
   output logic                  wfull,
   output logic                  rempty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [DATA_DEPTH:0]   fifo_cnt,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int PW = DATA_DEPTH + 1;
   localparam logic [PW-1:0] AF = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE = PW'(AE_LEVEL);
   logic [PW-1:0] wptr, rptr;
   logic push, pop;
   assign push = wr_en & ~wfull;
   assign pop  = rd_en & ~rempty;
   fifo_ptr #(.W(PW)) u_wptr (.clk(clk), .rst(rst), .en(push), .ptr(wptr));
   fifo_ptr #(.W(PW)) u_rptr (.clk(clk), .rst(rst), .en(pop),  .ptr(rptr));
   assign waddr        = wptr[DATA_DEPTH-1:0];
   assign raddr        = rptr[DATA_DEPTH-1:0];
   assign rempty       = wptr == rptr;
   assign wfull        = (wptr[DATA_DEPTH] != rptr[DATA_DEPTH]) && (waddr == raddr);
   assign fifo_cnt     = wptr - rptr;
   assign almost_full  = fifo_cnt >= AF;
   assign almost_empty = fifo_cnt <= AE;
   // latch rejected requests until reset so lost or bogus transfers are never missed
   always_ff @(posedge clk)
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflow | (wr_en & wfull);
         underflow <= underflow | (rd_en & rempty);
      end
endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// tb_fifo_ctrl_sync: table-driven directed check of the FIFO controller at depth 8
module tb_fifo_ctrl_sync;
   logic clk = 1'b0;
   logic rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
   logic [2:0] waddr, raddr;
   logic [3:0] fifo_cnt;
   logic wfull, rempty, almost_full, almost_empty, overflow, underflow;
   int checks = 0, errors = 0;

   typedef struct {
      logic rst, wr, rd;
      logic [2:0] wa, ra;
      logic [3:0] cnt;
      logic full, empty, af, ae, ov, un;
   } vec_t;
   vec_t vecs[$];

   fifo_ctrl_sync #(.DATA_DEPTH(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .waddr(waddr), .raddr(raddr), .wfull(wfull), .rempty(rempty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .fifo_cnt(fifo_cnt), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, w, d, input int wa, ra, cnt, input logic ov, un);
      vec_t v;
      v.rst = r; v.wr = w; v.rd = d;
      v.wa = 3'(wa); v.ra = 3'(ra); v.cnt = 4'(cnt);
      v.full = (cnt == 8); v.empty = (cnt == 0);
      v.af = (cnt >= 6); v.ae = (cnt <= 1);
      v.ov = ov; v.un = un;
      vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v, input string name);
      logic [15:0] act, exp;
      @(negedge clk);
      rst = v.rst; wr_en = v.wr; rd_en = v.rd;
      @(posedge clk);
      #1;
      act = {waddr, raddr, fifo_cnt, wfull, rempty, almost_full, almost_empty, overflow, underflow};
      exp = {v.wa, v.ra, v.cnt, v.full, v.empty, v.af, v.ae, v.ov, v.un};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got wa=%0d ra=%0d cnt=%0d full=%b empty=%b af=%b ae=%b ov=%b un=%b, want wa=%0d ra=%0d cnt=%0d full=%b empty=%b af=%b ae=%b ov=%b un=%b",
            name, waddr, raddr, fifo_cnt, wfull, rempty, almost_full, almost_empty, overflow, underflow,
            v.wa, v.ra, v.cnt, v.full, v.empty, v.af, v.ae, v.ov, v.un);
      end
   endtask

   initial begin
      vec_t v;
      add(1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 8; k++) add(0, 1, 0, k % 8, 0, k, 0, 0);
      add(0, 1, 0, 0, 0, 8, 1, 0);
      add(0, 0, 0, 0, 0, 8, 1, 0);
      for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, k % 8, 8 - k, 1, 0);
      add(0, 0, 1, 0, 0, 0, 1, 1);
      add(0, 0, 0, 0, 0, 0, 1, 1);
      add(1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 3; k++) add(0, 1, 0, k, 0, k, 0, 0);
      for (int k = 1; k <= 20; k++) add(0, 1, 1, (3 + k) % 8, k % 8, 3, 0, 0);
      for (int k = 1; k <= 5; k++) add(0, 1, 0, (7 + k) % 8, 4, 3 + k, 0, 0);
      add(0, 1, 1, 4, 5, 7, 1, 0);
      for (int k = 1; k <= 7; k++) add(0, 0, 1, 4, (5 + k) % 8, 7 - k, 1, 0);
      add(0, 1, 1, 5, 4, 1, 1, 1);
      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));
      // hand sequence: grow to count 5, then reset with a push pending
      for (int k = 1; k <= 4; k++) begin
         v = '{0, 1, 0, 3'((5 + k) % 8), 3'd4, 4'(1 + k), 0, 0, (1 + k) >= 6, 0, 1, 1};
         apply(v, $sformatf("refill%0d", k));
      end
      v = '{1, 1, 0, 3'd0, 3'd0, 4'd0, 0, 1, 0, 1, 0, 0};
      apply(v, "mid_reset");
      v = '{0, 0, 0, 3'd0, 3'd0, 4'd0, 0, 1, 0, 1, 0, 0};
      apply(v, "post_reset_idle");
      v = '{0, 1, 0, 3'd1, 3'd0, 4'd1, 0, 0, 0, 1, 0, 0};
      apply(v, "post_reset_push");
      v = '{0, 0, 1, 3'd1, 3'd1, 4'd0, 0, 1, 0, 1, 0, 0};
      apply(v, "post_reset_pop");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
